// File: rtl/tmr_pre_pkg.sv
// rtl/tmr_pre_pkg.sv - register map, control layout and edge-select helpers for tmr_pre
package tmr_pre_pkg;

    localparam logic [4:0] PRE_CR  = 5'h00;
    localparam logic [4:0] PRE_FLT = 5'h04;
    localparam logic [4:0] PRE_DIV = 5'h08;
    localparam logic [4:0] PRE_ST  = 5'h0C;
    localparam logic [4:0] PRE_EVC = 5'h10;

    localparam logic [1:0] ESEL_RISE = 2'b00;
    localparam logic [1:0] ESEL_FALL = 2'b01;
    localparam logic [1:0] ESEL_BOTH = 2'b10;
    localparam logic [1:0] ESEL_NONE = 2'b11;

    typedef struct packed {
        logic [1:0] esel;
        logic       en;
    } pre_cr_v;

    function automatic logic edge_sel(input logic [1:0] esel, input logic rise, input logic fall);
        edge_sel = 1'b0;
        case (esel)
            ESEL_RISE: edge_sel = rise;
            ESEL_FALL: edge_sel = fall;
            ESEL_BOTH: edge_sel = rise | fall;
            ESEL_NONE: edge_sel = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pre_flt.sv
// rtl/pre_flt.sv - glitch filter: level follows input after flt_len+1 stable differing cycles
module pre_flt #(
    parameter int flt_w = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s,
    input  logic [flt_w-1:0] flt_len,
    input  logic             clr,
    input  logic             bypass,
    output logic             f
);

    logic [flt_w-1:0] cnt;

    // Counter stops at flt_len and copies there, so all-ones flt_len never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f   <= 1'b0;
            cnt <= '0;
        end else if (bypass) begin
            f   <= s;
            cnt <= '0;
        end else if (clr || (s == f)) begin
            cnt <= '0;
        end else if (cnt == flt_len) begin
            f   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reg_we.sv
// rtl/reg_we.sv - register write-strobe decode for one full-width address
module reg_we #(
    parameter int           aw  = 5,
    parameter logic [aw-1:0] adr = '0
) (
    input  logic [aw-1:0] addr,
    input  logic          we,
    output logic          hit
);

    assign hit = we && (addr == adr);

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - multi-stage flop synchronizer for an asynchronous single-bit input
module sync #(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [stages-1:0] ff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= '0;
        end else begin
            ff <= {ff[stages-2:0], d};
        end
    end

    assign q = ff[stages-1];

endmodule

// File: rtl/tmr_pre.sv
// rtl/tmr_pre.sv - timer input prescaler: sync, filter, edge select, divide; TMR_PRE_EVC_EN adds event counter
module tmr_pre
    import tmr_pre_pkg::*;
#(
    parameter int flt_w = 4,
    parameter int div_w = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        ext_in,
    output logic        pre_out
);

    pre_cr_v          cr;
    logic [flt_w-1:0] flt_len;
    logic [div_w-1:0] div;
    logic [div_w-1:0] dc;
    logic             ovr;
    logic             s, f, f_d, req, evt;
    logic             hit_cr, hit_flt, hit_div, hit_st;
    logic             unused_wd;

    assign unused_wd = ^wd;

    reg_we #(.aw(5), .adr(PRE_CR))  u_we_cr  (.addr(addr), .we(we), .hit(hit_cr));
    reg_we #(.aw(5), .adr(PRE_FLT)) u_we_flt (.addr(addr), .we(we), .hit(hit_flt));
    reg_we #(.aw(5), .adr(PRE_DIV)) u_we_div (.addr(addr), .we(we), .hit(hit_div));
    reg_we #(.aw(5), .adr(PRE_ST))  u_we_st  (.addr(addr), .we(we), .hit(hit_st));

    sync #(.stages(2)) u_sync (.clk(clk), .rstn(rstn), .d(ext_in), .q(s));

    pre_flt #(.flt_w(flt_w)) u_flt (
        .clk    (clk),
        .rstn   (rstn),
        .s      (s),
        .flt_len(flt_len),
        .clr    (hit_flt),
        .bypass (!cr.en),
        .f      (f)
    );

    assign evt = cr.en && edge_sel(cr.esel, f && !f_d, !f && f_d);

    // req is the divider's pulse request; pre_out retimes it so a back-to-back request shows as overrun.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cr      <= '0;
            flt_len <= '0;
            div     <= '0;
            f_d     <= 1'b0;
            dc      <= '0;
            req     <= 1'b0;
            pre_out <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (hit_cr)  cr      <= pre_cr_v'(wd[2:0]);
            if (hit_flt) flt_len <= wd[flt_w-1:0];
            if (hit_div) div     <= wd[div_w-1:0];
            f_d <= cr.en ? f : s;
            if (!cr.en) begin
                dc      <= '0;
                req     <= 1'b0;
                pre_out <= 1'b0;
            end else begin
                req <= 1'b0;
                if (hit_div) begin
                    dc <= '0;
                end else if (evt) begin
                    if (dc == div) begin
                        dc  <= '0;
                        req <= 1'b1;
                    end else begin
                        dc <= dc + 1'b1;
                    end
                end
                pre_out <= req;
            end
            if (req && pre_out) begin
                ovr <= 1'b1;
            end else if (hit_st && wd[0]) begin
                ovr <= 1'b0;
            end
        end
    end

`ifdef TMR_PRE_EVC_EN
    logic [31:0] evc;
    logic        hit_evc;

    reg_we #(.aw(5), .adr(PRE_EVC)) u_we_evc (.addr(addr), .we(we), .hit(hit_evc));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evc <= '0;
        end else if (hit_evc) begin
            evc <= '0;
        end else if (evt) begin
            evc <= evc + 32'd1;
        end
    end
`endif

    always_comb begin
        rd = '0;
        case (addr)
            PRE_CR:  rd[2:0]       = cr;
            PRE_FLT: rd[flt_w-1:0] = flt_len;
            PRE_DIV: rd[div_w-1:0] = div;
            PRE_ST:  rd[1:0]       = {f, ovr};
`ifdef TMR_PRE_EVC_EN
            PRE_EVC: rd            = evc;
`else
            PRE_EVC: rd            = '0;
`endif
            default: rd            = '0;
        endcase
    end

endmodule

// File: tb/tb_tmr_pre.sv
// tb/tb_tmr_pre.sv - directed self-checking bench for tmr_pre
module tb_tmr_pre;
    import tmr_pre_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [4:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        ext_in = 1'b0;
    logic        pre_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int npulse = 0;
    int last_rise = 0;
    int run = 0;
    int maxrun = 0;
    logic po_prev = 1'b0;
    int base;
    int t0;

    tmr_pre #(.flt_w(4), .div_w(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .rd     (rd),
        .ext_in (ext_in),
        .pre_out(pre_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (pre_out && !po_prev) begin
            npulse = npulse + 1;
            last_rise = cyc;
        end
        po_prev = pre_out;
        run = pre_out ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] mask,
                         input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd & mask, exp);
    endtask

    task automatic rise_fall(input int hi, input int lo);
        ext_in = 1'b1;
        tick(hi);
        ext_in = 1'b0;
        tick(lo);
    endtask

    initial begin
        // Reset state
        #2 rstn = 1'b0;
        #1;
        chk("rst_pre_out", {31'b0, pre_out}, 32'd0);
        rdchk("rst_cr",  PRE_CR,  32'hFFFF_FFFF, 32'd0);
        rdchk("rst_flt", PRE_FLT, 32'hFFFF_FFFF, 32'd0);
        rdchk("rst_div", PRE_DIV, 32'hFFFF_FFFF, 32'd0);
        rdchk("rst_st",  PRE_ST,  32'hFFFF_FFFF, 32'd0);
        rdchk("rst_evc", PRE_EVC, 32'hFFFF_FFFF, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // Rise, no filter
        wr(PRE_CR, 32'h1);
        wr(PRE_FLT, 32'h0);
        wr(PRE_DIV, 32'h0);
        rdchk("cr_rb", PRE_CR, 32'hFFFF_FFFF, 32'h1);
        tick(4);
        base = npulse;
        ext_in = 1'b1;
        t0 = cyc;
        tick(10);
        chk("rise_cnt", npulse - base, 32'd1);
        chk("rise_lat", last_rise - t0, 32'd5);
        rdchk("rise_lvl", PRE_ST, 32'hFFFF_FFFF, 32'h2);
        tick(1);
        ext_in = 1'b0;
        tick(10);
        chk("fall_ignored", npulse - base, 32'd1);

        // Glitch rejection, FLT=3
        wr(PRE_FLT, 32'h3);
        tick(3);
        base = npulse;
        rise_fall(3, 12);
        chk("glitch_rej", npulse - base, 32'd0);
        ext_in = 1'b1;
        t0 = cyc;
        tick(6);
        ext_in = 1'b0;
        tick(15);
        chk("glitch_pass", npulse - base, 32'd1);
        chk("glitch_lat", last_rise - t0, 32'd8);

        // Maximum filter length
        wr(PRE_FLT, 32'hF);
        tick(2);
        base = npulse;
        ext_in = 1'b1;
        t0 = cyc;
        tick(25);
        chk("maxflt_cnt", npulse - base, 32'd1);
        chk("maxflt_lat", last_rise - t0, 32'd20);
        ext_in = 1'b0;
        tick(25);

        // Divider DIV=4
        wr(PRE_FLT, 32'h0);
        wr(PRE_DIV, 32'h4);
        tick(3);
        base = npulse;
        for (int i = 1; i <= 15; i++) begin
            rise_fall(4, 4);
            chk($sformatf("div_edge%0d", i), npulse - base, i / 5);
        end

        // Both edges with overrun, then disable mid-pulse
        wr(PRE_DIV, 32'h0);
        wr(PRE_CR, 32'h5);
        tick(2);
        for (int i = 0; i < 12; i++) begin
            ext_in = ~ext_in;
            tick(1);
        end
        ext_in = ~ext_in;
        wr(PRE_CR, 32'h0);
        chk("dis_po_hold", {31'b0, pre_out}, 32'd1);
        tick(1);
        chk("dis_po_drop", {31'b0, pre_out}, 32'd0);
        chk("ovr_held_hi", (maxrun > 1) ? 32'd1 : 32'd0, 32'd1);
        rdchk("ovr_set", PRE_ST, 32'h1, 32'h1);
        tick(1);
        wr(PRE_ST, 32'h1);
        rdchk("ovr_clr", PRE_ST, 32'h1, 32'h0);

        // Disable / re-enable clears divider and makes no spurious edge
        ext_in = 1'b0;
        tick(6);
        wr(PRE_DIV, 32'h2);
        wr(PRE_CR, 32'h1);
        tick(4);
        base = npulse;
        ext_in = 1'b1;
        tick(10);
        wr(PRE_CR, 32'h0);
        ext_in = 1'b0;
        tick(5);
        ext_in = 1'b1;
        tick(5);
        wr(PRE_CR, 32'h1);
        tick(10);
        chk("reen_no_pulse", npulse - base, 32'd0);
        ext_in = 1'b0;
        tick(4);
        rise_fall(4, 4);
        rise_fall(4, 4);
        chk("reen_dc_2", npulse - base, 32'd0);
        rise_fall(4, 4);
        chk("reen_dc_3", npulse - base, 32'd1);

`ifdef TMR_PRE_EVC_EN
        // Event counter
        wr(PRE_DIV, 32'h2);
        wr(PRE_EVC, 32'h0);
        tick(2);
        base = npulse;
        for (int i = 0; i < 7; i++) rise_fall(4, 4);
        tick(4);
        rdchk("evc_7", PRE_EVC, 32'hFFFF_FFFF, 32'd7);
        chk("evc_pulses", npulse - base, 32'd2);
        tick(1);
        wr(PRE_EVC, 32'h5);
        rdchk("evc_clr", PRE_EVC, 32'hFFFF_FFFF, 32'd0);
`else
        wr(PRE_EVC, 32'hFFFF_FFFF);
        rdchk("evc_absent", PRE_EVC, 32'hFFFF_FFFF, 32'd0);
`endif
        rdchk("unmapped_14", 5'h14, 32'hFFFF_FFFF, 32'd0);
        rdchk("unaligned_01", 5'h01, 32'hFFFF_FFFF, 32'd0);

        // Asynchronous reset mid-pulse
        tick(1);
        wr(PRE_DIV, 32'h0);
        tick(3);
        ext_in = 1'b1;
        tick(5);
        chk("arst_po_before", {31'b0, pre_out}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_po_after", {31'b0, pre_out}, 32'd0);
        rdchk("arst_cr", PRE_CR, 32'hFFFF_FFFF, 32'd0);
        rdchk("arst_st", PRE_ST, 32'hFFFF_FFFF, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
